// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 register-ROM configuration sequencer.
package ov7670_cfg_pkg;

  localparam int          ROM_AW         = 7;
  localparam logic [15:0] DELAY_MARK_DEF = 16'hFFF0;
  localparam logic [15:0] END_MARK_DEF   = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    DELAY,
    NEXT,
    DONE,
    FAIL
  } cfg_state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ov7670_cfg_seq_delay_timer.sv
// Load / count-down timer used for ROM delay markers; zero is high when the count is 0.
module cfg_delay_timer
  import ov7670_cfg_pkg::*;
#(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = cnt_width(CYCLES);

  logic [W-1:0] cnt_reg;

  // Loading CYCLES-1 makes the owner stall exactly CYCLES cycles, the last one seeing zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(CYCLES - 1);
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ov7670_cfg_seq.sv
// OV7670 configuration sequencer: walks the register ROM and issues one SCCB write per entry.
// Optional CFG_RETRY_EN: resend a NACKed entry up to MAX_RETRY times before failing.
module ov7670_cfg_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int          ROM_DEPTH    = 75,
  parameter int          DELAY_CYCLES = 100000,
  parameter logic [15:0] DELAY_MARK   = DELAY_MARK_DEF,
`ifdef CFG_RETRY_EN
  parameter int          MAX_RETRY    = 3,
`endif
  parameter logic [15:0] END_MARK     = END_MARK_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_valid,
  input  logic              sccb_ready,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_data,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_DEPTH - 1);

  cfg_state_e  state_reg;
  logic [15:0] word_reg;
  logic        delay_load;
  logic        delay_en;
  logic        delay_zero;

`ifdef CFG_RETRY_EN
  localparam int RW = cnt_width(MAX_RETRY + 1);
  logic [RW-1:0] retry_reg;
`endif

  assign delay_load = (state_reg == DECODE) && (word_reg != END_MARK) && (word_reg == DELAY_MARK);
  assign delay_en   = (state_reg == DELAY);

  cfg_delay_timer #(
    .CYCLES (DELAY_CYCLES)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (delay_load),
    .en      (delay_en),
    .zero    (delay_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      rom_addr   <= '0;
      sccb_valid <= 1'b0;
      sccb_reg   <= '0;
      sccb_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            rom_addr  <= '0;
`ifdef CFG_RETRY_EN
            retry_reg <= '0;
`endif
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          word_reg  <= rom_data;
          state_reg <= DECODE;
        end
        DECODE: begin
          if (word_reg == END_MARK) begin
            state_reg <= DONE;
          end else if (word_reg == DELAY_MARK) begin
            state_reg <= DELAY;
          end else begin
            sccb_reg   <= word_reg[15:8];
            sccb_data  <= word_reg[7:0];
            sccb_valid <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          // Payload stays frozen until the master takes it.
          if (sccb_ready) begin
            sccb_valid <= 1'b0;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (sccb_done) begin
            if (!sccb_nack) begin
              state_reg <= NEXT;
`ifdef CFG_RETRY_EN
            end else if (retry_reg < RW'(MAX_RETRY)) begin
              retry_reg  <= retry_reg + 1'b1;
              sccb_valid <= 1'b1;
              state_reg  <= ISSUE;
`endif
            end else begin
              state_reg <= FAIL;
            end
          end
        end
        DELAY: begin
          if (delay_zero) begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
`ifdef CFG_RETRY_EN
          retry_reg <= '0;
`endif
          if (rom_addr == LAST_ADDR) begin
            state_reg <= DONE;
          end else begin
            rom_addr  <= rom_addr + 1'b1;
            state_reg <= FETCH;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        FAIL: begin
          busy      <= 1'b0;
          error     <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
